uart_pwm_readback_tx: RTL
=========================

Name: uart_pwm_readback_tx

Overview:
- UART transmitter that sends the 9 PWM duty registers back to the host, so the host can confirm what the receive path stored.
- On a start request it snapshots all duty values. It then serializes them as 8N1 bytes, 2 bytes per 16-bit word, low byte first.
- Timing matches the receive side: 50 MHz clk, 115200 baud.
- Sits in uart_pwm_top beside the receiver. Inputs come from the data-store duty outputs; tx drives the board UART TX pin.

Parameters:
- CLOCKS_PER_PULSE, 434, clk cycles per UART bit.
- BITS_PER_WORD, 8, data bits per UART frame.
- WIDTH, 16, duty word width; must be a multiple of BITS_PER_WORD.
- CHANNELS, 9, number of duty words sent per readback.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  readback request; level sampled each clk
- duty0..duty8  in  16 each  duty values to report
- tx  out  1  UART serial output, idle high
- busy  out  1  high while a readback is in progress
- done  out  1  one-cycle pulse when the last stop bit finishes
- word_idx  out  4  index of the word currently being sent (0..CHANNELS-1)

Behaviour:
- Reset values:
  - tx=1, busy=0, done=0, word_idx=0.
  - FSM=IDLE; all counters 0; snapshot registers 0.
- Reset is asynchronous and may arrive mid-frame. tx returns high immediately, the frame is abandoned, and no done pulse is produced.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - start=1 sampled at edge N: capture duty0..duty8 into the snapshot, set busy=1, go to START_BIT.
  - tx goes low at edge N+1.
  - start while busy=1 is ignored; no queuing.
- Bit timing:
  - A baud counter runs 0..CLOCKS_PER_PULSE-1.
  - Every bit, start/data/stop, is held exactly CLOCKS_PER_PULSE cycles.
- START_BIT: tx=0, then go to DATA_BITS.
- DATA_BITS:
  - Sends BITS_PER_WORD bits, LSB first, from the current byte.
  - Bit counter runs 0..BITS_PER_WORD-1, then go to STOP_BIT.
- STOP_BIT: tx=1 for one bit time, then the byte sequencer advances.
- Byte sequencer:
  - byte_sel runs 0..WIDTH/BITS_PER_WORD-1. byte_sel=0 sends snapshot[word_idx][7:0]; byte_sel=1 sends [15:8].
  - After the last byte of a word, word_idx increments.
  - After the last byte of word CHANNELS-1, go to IDLE.
- No idle gap between bytes: the next start bit begins on the cycle after the stop bit ends.
- Completion:
  - done=1 for exactly one cycle, on the cycle busy falls to 0.
  - word_idx returns to 0 at the same edge.
- Readback duration: CHANNELS*2*10*CLOCKS_PER_PULSE cycles. Defaults give 180*434 = 78120 cycles.
- Duty inputs may change at any time; transmitted data always comes from the snapshot.
- start held high continuously: a new readback starts on the cycle after done. This is the only back-to-back case.

Optional Feature:
- Macro: UART_TX_CHECKSUM_EN.
- Defined: after the last word, one extra 8N1 byte is sent. Its value is the XOR of all 2*CHANNELS transmitted data bytes. word_idx holds CHANNELS during this byte. done follows its stop bit, and duration grows by 10*CLOCKS_PER_PULSE.
- Undefined: no checksum byte; behaviour exactly as above.

Test Plan:
- Reset/idle: CLOCKS_PER_PULSE=4, hold rst_n=0, then release -> tx=1, busy=0, done=0, word_idx=0; tx stays high for 100 cycles with start=0.
- Single readback: duty0=16'h1234, duty1..8=16'h0000..16'h0007 (dutyk=k-1), pulse start -> tx low exactly 1 cycle after start sampled.
  - First byte decodes 8'h34, second 8'h12, then 8'h00 8'h00 8'h01 8'h00 ... 8'h07 8'h00.
  - done pulse at cycle 720 after start; busy high for exactly those 720 cycles.
- Snapshot: start readback with duty0=16'hAAAA, change duty0 to 16'h5555 one cycle later -> bytes 8'hAA 8'hAA are sent.
- Start while busy: pulse start mid-word 3 -> ignored, and exactly 18 bytes are sent before done. Start held high through done -> second readback begins the cycle after done.
- Reset mid-frame: assert rst_n=0 during DATA_BITS of word 4 -> tx=1 immediately; no done pulse. After release, a new start sends a full frame from word 0.
- Checksum (UART_TX_CHECKSUM_EN): all duties 16'hFFFF except duty8=16'h00FF -> 19th byte = 8'hFF (17 bytes of FF XOR 1 byte of 00); done at cycle 760.

Source files
------------

// File: rtl/uart_pwm_readback_tx.sv
// UART readback transmitter: snapshots the nine PWM duty words and sends them as 8N1 bytes, low byte first.
// Optional feature macro: UART_TX_CHECKSUM_EN appends an XOR checksum byte after the last word.
module uart_pwm_readback_tx #(
  parameter int unsigned CLOCKS_PER_PULSE = 434,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned WIDTH            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] duty0,
  input  logic [WIDTH-1:0] duty1,
  input  logic [WIDTH-1:0] duty2,
  input  logic [WIDTH-1:0] duty3,
  input  logic [WIDTH-1:0] duty4,
  input  logic [WIDTH-1:0] duty5,
  input  logic [WIDTH-1:0] duty6,
  input  logic [WIDTH-1:0] duty7,
  input  logic [WIDTH-1:0] duty8,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [3:0]       word_idx
);

  localparam int unsigned CHANNELS = 9;
  localparam int unsigned BYTES    = WIDTH / BITS_PER_WORD;
  localparam int unsigned BAUD_W   = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned BIT_W    = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned BYTE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t                   state_q, state_d;
  logic [BAUD_W-1:0]        baud_q, baud_d, baud_nxt_c;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [BYTE_W-1:0]        byte_q, byte_d;
  logic [3:0]               word_d;
  logic                     tx_d, busy_d, done_d, load_c;
  logic                     baud_end_c, bit_last_c, byte_last_c, word_last_c;
  logic [WIDTH-1:0]         snap_q [CHANNELS];
  logic [WIDTH-1:0]         duty_c [CHANNELS];
  logic [WIDTH-1:0]         cur_word_c;
  logic [BITS_PER_WORD-1:0] data_byte_c, cur_byte_c;
`ifdef UART_TX_CHECKSUM_EN
  logic [BITS_PER_WORD-1:0] csum_q, csum_d;
  logic                     csum_phase_c;
`endif

  assign duty_c[0] = duty0;
  assign duty_c[1] = duty1;
  assign duty_c[2] = duty2;
  assign duty_c[3] = duty3;
  assign duty_c[4] = duty4;
  assign duty_c[5] = duty5;
  assign duty_c[6] = duty6;
  assign duty_c[7] = duty7;
  assign duty_c[8] = duty8;

  // Byte currently on the wire, selected from the snapshot (or the checksum)
  assign cur_word_c  = snap_q[word_idx];
  assign data_byte_c = BITS_PER_WORD'(cur_word_c >> (BITS_PER_WORD * byte_q));
`ifdef UART_TX_CHECKSUM_EN
  assign csum_phase_c = (word_idx == 4'(CHANNELS));
  assign cur_byte_c   = csum_phase_c ? csum_q : data_byte_c;
`else
  assign cur_byte_c   = data_byte_c;
`endif

  assign baud_end_c  = (baud_q == BAUD_W'(CLOCKS_PER_PULSE - 1));
  assign baud_nxt_c  = baud_end_c ? '0 : baud_q + BAUD_W'(1);
  assign bit_last_c  = (bit_q == BIT_W'(BITS_PER_WORD - 1));
  assign byte_last_c = (byte_q == BYTE_W'(BYTES - 1));
  assign word_last_c = (word_idx == 4'(CHANNELS - 1));

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_idx;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    load_c  = 1'b0;
`ifdef UART_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START_BIT;
          load_c  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          word_d  = '0;
`ifdef UART_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      START_BIT: begin
        tx_d   = 1'b0;
        baud_d = baud_nxt_c;
        if (baud_end_c) begin
          state_d = DATA_BITS;
          bit_d   = '0;
        end
      end
      DATA_BITS: begin
        tx_d   = cur_byte_c[bit_q];
        baud_d = baud_nxt_c;
        if (baud_end_c) begin
          if (bit_last_c) state_d = STOP_BIT;
          else            bit_d   = bit_q + BIT_W'(1);
        end
      end
      STOP_BIT: begin
        tx_d   = 1'b1;
        baud_d = baud_nxt_c;
        if (baud_end_c) begin
          state_d = START_BIT;
`ifdef UART_TX_CHECKSUM_EN
          csum_d = csum_q ^ cur_byte_c;
          if (csum_phase_c) begin
            state_d = IDLE;
            word_d  = '0;
            done_d  = 1'b1;
          end else
`endif
          if (!byte_last_c) begin
            byte_d = byte_q + BYTE_W'(1);
          end else begin
            byte_d = '0;
            if (!word_last_c) begin
              word_d = word_idx + 4'd1;
            end else begin
`ifdef UART_TX_CHECKSUM_EN
              word_d = 4'(CHANNELS);
`else
              state_d = IDLE;
              word_d  = '0;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters, snapshot and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      word_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) snap_q[c] <= '0;
`ifdef UART_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      word_idx <= word_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      if (load_c) begin
        for (int c = 0; c < CHANNELS; c++) snap_q[c] <= duty_c[c];
      end
`ifdef UART_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule
